// File: rtl/qam_demapper_hard.sv
// Hard-decision Gray-PAM QAM demapper (BPSK..QAM1024) with a per-frame
// squared-error accumulator for link-quality monitoring.
module qam_demapper_hard #(
    parameter int pDAT_W = 8,
    parameter int pSTEP  = 4,
    parameter int pERR_W = 24
) (
    input  logic                     iclk,
    input  logic                     ireset,
    input  logic                     iclkena,
    input  logic                     ival,
    input  logic                     isop,
    input  logic                     ieop,
    input  logic [3:0]               iqam,
    input  logic signed [pDAT_W-1:0] idat_re,
    input  logic signed [pDAT_W-1:0] idat_im,
    output logic                     oval,
    output logic [4:0]               odat_re,
    output logic [4:0]               odat_im,
    output logic                     oerr_val,
    output logic [pERR_W-1:0]        oerr,
    output logic [15:0]              ocnt
);

    localparam int EW  = pDAT_W + 2;
    localparam int SQW = 2 * EW;
    localparam int AW  = ((pERR_W > SQW) ? pERR_W : SQW) + 1;

    typedef enum logic {StIdle, StActive} state_t;

    // {n_re, n_im}; unsupported codes fall back to QPSK, BPSK keeps one imag bit
    function automatic logic [5:0] axis_bits(input logic [3:0] qam);
        logic [3:0] m;
        logic [2:0] nr, ni;
        m  = (qam >= 4'd1 && qam <= 4'd10) ? qam : 4'd2;
        nr = 3'((m + 4'd1) >> 1);
        ni = (m == 4'd1) ? 3'd1 : 3'(m >> 1);
        return {nr, ni};
    endfunction

    // Offset into the non-negative domain, floor-divide by level spacing, clamp
    function automatic logic [4:0] slice_pos(input logic signed [pDAT_W-1:0] x,
                                             input logic [2:0] n);
        int l, t, p;
        l = 1 << n;
        t = int'(x) + l * pSTEP;
        if (t < 0) p = 0;
        else       p = t / (2 * pSTEP);
        if (p > l - 1) p = l - 1;
        return p[4:0];
    endfunction

    function automatic logic signed [EW-1:0] level_of(input logic [4:0] p, input logic [2:0] n);
        int l, v;
        l = 1 << n;
        v = (2 * int'(p) - (l - 1)) * pSTEP;
        return v[EW-1:0];
    endfunction

    logic                     s1_val, s1_sop, s1_eop;
    logic [3:0]               s1_qam;
    logic signed [pDAT_W-1:0] s1_re, s1_im;

    logic                     s2_val, s2_sop, s2_eop;
    logic [4:0]               s2_pre, s2_pim;
    logic signed [EW-1:0]     s2_lre, s2_lim;
    logic signed [pDAT_W-1:0] s2_xre, s2_xim;

    logic                     s3_sop, s3_eop;
    logic [SQW-1:0]           s3_err;

    logic [2:0]               n_re, n_im;
    logic [4:0]               p_re, p_im;
    logic signed [EW-1:0]     l_re, l_im;
    logic signed [EW-1:0]     e_re, e_im;
    logic signed [SQW-1:0]    sq_re, sq_im;
    logic [SQW-1:0]           sym_err;

    state_t                   state, state_next;
    logic [pERR_W-1:0]        acc, acc_next;
    logic [15:0]              cnt, cnt_next;
    logic                     strobe;
    logic [AW-1:0]            err_ext, sum;

    // S1: register raw inputs with frame flags qualified by ival
    always_ff @(posedge iclk or posedge ireset) begin
        if (ireset) begin
            s1_val <= 1'b0;
            s1_sop <= 1'b0;
            s1_eop <= 1'b0;
            s1_qam <= 4'd0;
            s1_re  <= '0;
            s1_im  <= '0;
        end else if (iclkena) begin
            s1_val <= ival;
            s1_sop <= ival & isop;
            s1_eop <= ival & ieop;
            s1_qam <= iqam;
            s1_re  <= idat_re;
            s1_im  <= idat_im;
        end
    end

    // S2 decision: grid position and reconstructed level per axis
    always_comb begin
        {n_re, n_im} = axis_bits(s1_qam);
        p_re = slice_pos(s1_re, n_re);
        p_im = slice_pos(s1_im, n_im);
        l_re = level_of(p_re, n_re);
        l_im = level_of(p_im, n_im);
    end

    // S2 register
    always_ff @(posedge iclk or posedge ireset) begin
        if (ireset) begin
            s2_val <= 1'b0;
            s2_sop <= 1'b0;
            s2_eop <= 1'b0;
            s2_pre <= '0;
            s2_pim <= '0;
            s2_lre <= '0;
            s2_lim <= '0;
            s2_xre <= '0;
            s2_xim <= '0;
        end else if (iclkena) begin
            s2_val <= s1_val;
            s2_sop <= s1_sop;
            s2_eop <= s1_eop;
            s2_pre <= p_re;
            s2_pim <= p_im;
            s2_lre <= l_re;
            s2_lim <= l_im;
            s2_xre <= s1_re;
            s2_xim <= s1_im;
        end
    end

    // S3 error: residual to the chosen level and its squared magnitude
    always_comb begin
        e_re    = EW'(s2_xre) - s2_lre;
        e_im    = EW'(s2_xim) - s2_lim;
        sq_re   = e_re * e_re;
        sq_im   = e_im * e_im;
        sym_err = $unsigned(sq_re) + $unsigned(sq_im);
    end

    // S3 register: decisions hold their last value between valid symbols
    always_ff @(posedge iclk or posedge ireset) begin
        if (ireset) begin
            oval    <= 1'b0;
            odat_re <= '0;
            odat_im <= '0;
            s3_sop  <= 1'b0;
            s3_eop  <= 1'b0;
            s3_err  <= '0;
        end else if (iclkena) begin
            oval   <= s2_val;
            s3_sop <= s2_sop;
            s3_eop <= s2_eop;
            s3_err <= sym_err;
            if (s2_val) begin
                odat_re <= s2_pre ^ (s2_pre >> 1);
                odat_im <= s2_pim ^ (s2_pim >> 1);
            end
        end
    end

    // Frame state register
    always_ff @(posedge iclk or posedge ireset) begin
        if (ireset)       state <= StIdle;
        else if (iclkena) state <= state_next;
    end

    // Frame next state: sop (re)starts, eop in a frame closes it
    always_comb begin
        state_next = state;
        if (oval) begin
            if (s3_sop)                          state_next = s3_eop ? StIdle : StActive;
            else if (state == StActive && s3_eop) state_next = StIdle;
        end
    end

    // Frame outputs: saturating accumulate/count and end-of-frame strobe
    always_comb begin
        acc_next = acc;
        cnt_next = cnt;
        strobe   = 1'b0;
        err_ext  = AW'(s3_err);
        sum      = AW'(acc) + err_ext;
        if (oval) begin
            if (s3_sop) begin
                acc_next = (err_ext > AW'({pERR_W{1'b1}})) ? '1 : err_ext[pERR_W-1:0];
                cnt_next = 16'd1;
                strobe   = s3_eop;
            end else if (state == StActive) begin
                acc_next = (sum > AW'({pERR_W{1'b1}})) ? '1 : sum[pERR_W-1:0];
                cnt_next = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
                strobe   = s3_eop;
            end
        end
    end

    // Frame accumulator and result registers
    always_ff @(posedge iclk or posedge ireset) begin
        if (ireset) begin
            acc      <= '0;
            cnt      <= '0;
            oerr_val <= 1'b0;
            oerr     <= '0;
            ocnt     <= '0;
        end else if (iclkena) begin
            acc      <= acc_next;
            cnt      <= cnt_next;
            oerr_val <= strobe;
            if (strobe) begin
                oerr <= acc_next;
                ocnt <= cnt_next;
            end
        end
    end

endmodule

// File: tb/tb_qam_demapper_hard.sv
// Directed self-checking bench for qam_demapper_hard (pDAT_W=8, pSTEP=4, pERR_W=24).
module tb_qam_demapper_hard;

    logic              iclk, ireset, iclkena, ival, isop, ieop;
    logic [3:0]        iqam;
    logic signed [7:0] idat_re, idat_im;
    logic              oval, oerr_val;
    logic [4:0]        odat_re, odat_im;
    logic [23:0]       oerr;
    logic [15:0]       ocnt;

    int n_checks = 0;
    int n_pass   = 0;
    int strobe_cnt = 0;
    int s0;
    logic en_last = 1'b0;

    qam_demapper_hard #(.pDAT_W(8), .pSTEP(4), .pERR_W(24)) dut (
        .iclk(iclk), .ireset(ireset), .iclkena(iclkena), .ival(ival), .isop(isop),
        .ieop(ieop), .iqam(iqam), .idat_re(idat_re), .idat_im(idat_im), .oval(oval),
        .odat_re(odat_re), .odat_im(odat_im), .oerr_val(oerr_val), .oerr(oerr), .ocnt(ocnt)
    );

    initial iclk = 1'b0;
    always #5 iclk = ~iclk;

    // Count frame strobes produced by enabled edges
    always @(posedge iclk) en_last <= iclkena;
    always @(negedge iclk) if (en_last && oerr_val) strobe_cnt = strobe_cnt + 1;

    task automatic tick();
        @(posedge iclk);
        #1;
    endtask

    task automatic drive(input logic v, input logic s, input logic e, input logic [3:0] q,
                         input int re, input int im);
        ival = v; isop = s; ieop = e; iqam = q; idat_re = 8'(re); idat_im = 8'(im);
    endtask

    task automatic send(input logic s, input logic e, input logic [3:0] q, input int re,
                        input int im);
        drive(1'b1, s, e, q, re, im);
        tick();
        drive(1'b0, 1'b0, 1'b0, 4'd2, 0, 0);
    endtask

    task automatic idle(input int n);
        drive(1'b0, 1'b0, 1'b0, 4'd2, 0, 0);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic test_reset();
        ireset = 1'b1;
        #1;
        n_checks++; if (oval !== 1'b0) $display("FAIL rst_oval: got %0d want 0", oval); else n_pass++;
        n_checks++; if (odat_re !== 5'd0) $display("FAIL rst_odat_re: got %0d want 0", odat_re); else n_pass++;
        n_checks++; if (odat_im !== 5'd0) $display("FAIL rst_odat_im: got %0d want 0", odat_im); else n_pass++;
        n_checks++; if (oerr_val !== 1'b0) $display("FAIL rst_oerr_val: got %0d want 0", oerr_val); else n_pass++;
        n_checks++; if (oerr !== 24'd0) $display("FAIL rst_oerr: got %0d want 0", oerr); else n_pass++;
        n_checks++; if (ocnt !== 16'd0) $display("FAIL rst_ocnt: got %0d want 0", ocnt); else n_pass++;
        tick(); tick();
        ireset = 1'b0;
        tick();
    endtask

    task automatic test_qpsk();
        send(1'b1, 1'b1, 4'd2, 5, -3);
        idle(1);
        n_checks++; if (oval !== 1'b0) $display("FAIL qpsk_early_oval: got %0d want 0", oval); else n_pass++;
        idle(1);
        n_checks++; if (oval !== 1'b1) $display("FAIL qpsk_oval: got %0d want 1", oval); else n_pass++;
        n_checks++; if (odat_re !== 5'd1) $display("FAIL qpsk_re: got %0d want 1", odat_re); else n_pass++;
        n_checks++; if (odat_im !== 5'd0) $display("FAIL qpsk_im: got %0d want 0", odat_im); else n_pass++;
        n_checks++; if (oerr_val !== 1'b0) $display("FAIL qpsk_early_strobe: got %0d want 0", oerr_val); else n_pass++;
        idle(1);
        n_checks++; if (oerr_val !== 1'b1) $display("FAIL qpsk_strobe: got %0d want 1", oerr_val); else n_pass++;
        n_checks++; if (oerr !== 24'd2) $display("FAIL qpsk_oerr: got %0d want 2", oerr); else n_pass++;
        n_checks++; if (ocnt !== 16'd1) $display("FAIL qpsk_ocnt: got %0d want 1", ocnt); else n_pass++;
        n_checks++; if (oval !== 1'b0) $display("FAIL qpsk_oval_drop: got %0d want 0", oval); else n_pass++;
        idle(1);
        n_checks++; if (oerr_val !== 1'b0) $display("FAIL qpsk_strobe_len: got %0d want 0", oerr_val); else n_pass++;
        n_checks++; if (oerr !== 24'd2) $display("FAIL qpsk_oerr_hold: got %0d want 2", oerr); else n_pass++;
        n_checks++; if (odat_re !== 5'd1) $display("FAIL qpsk_odat_hold: got %0d want 1", odat_re); else n_pass++;
    endtask

    // Single-symbol frames: {qam, re, im, gray_re, gray_im, err}
    task automatic test_slicer();
        int vec [8][6] = '{
            '{4,  12, -12,  2, 0,  0},   // QAM16 on-grid
            '{4,   8, -12,  2, 0, 16},   // QAM16 tie resolves upward
            '{10, 127, -128, 16, 0, 25}, // QAM1024 clamp both edges
            '{15,  5,  -3,  1, 0,  2},   // illegal code -> QPSK
            '{6,  -1,  20,  2, 5,  9},   // QAM64
            '{3,  -9,   2,  0, 1, 13},   // 8-point: 2 bits re, 1 bit im
            '{1,   5,  -3,  1, 0,  2},   // BPSK keeps 1 imag bit
            '{0, -100, 100, 0, 1, 96*96+96*96}  // code 0 -> QPSK, far clamp
        };
        for (int k = 0; k < 8; k++) begin
            send(1'b1, 1'b1, 4'(vec[k][0]), vec[k][1], vec[k][2]);
            idle(2);
            n_checks++; if (oval !== 1'b1 || odat_re !== 5'(vec[k][3]))
                $display("FAIL slice_re[%0d]: got val=%0d re=%0d want val=1 re=%0d", k, oval, odat_re, vec[k][3]);
            else n_pass++;
            n_checks++; if (odat_im !== 5'(vec[k][4]))
                $display("FAIL slice_im[%0d]: got %0d want %0d", k, odat_im, vec[k][4]);
            else n_pass++;
            idle(1);
            n_checks++; if (oerr_val !== 1'b1 || oerr !== 24'(vec[k][5]) || ocnt !== 16'd1)
                $display("FAIL slice_err[%0d]: got val=%0d err=%0d cnt=%0d want 1/%0d/1", k, oerr_val, oerr, ocnt, vec[k][5]);
            else n_pass++;
            idle(1);
        end
    endtask

    task automatic test_back_to_back();
        send(1'b1, 1'b0, 4'd2, 5, -3);
        send(1'b0, 1'b0, 4'd4, 12, -12);
        send(1'b0, 1'b1, 4'd10, 127, -128);
        n_checks++; if (oval !== 1'b1 || odat_re !== 5'd1) $display("FAIL b2b_sym0: got val=%0d re=%0d want 1/1", oval, odat_re); else n_pass++;
        idle(1);
        n_checks++; if (oval !== 1'b1 || odat_re !== 5'd2 || odat_im !== 5'd0) $display("FAIL b2b_sym1: got val=%0d re=%0d im=%0d want 1/2/0", oval, odat_re, odat_im); else n_pass++;
        idle(1);
        n_checks++; if (oval !== 1'b1 || odat_re !== 5'd16 || odat_im !== 5'd0) $display("FAIL b2b_sym2: got val=%0d re=%0d im=%0d want 1/16/0", oval, odat_re, odat_im); else n_pass++;
        n_checks++; if (oerr_val !== 1'b0) $display("FAIL b2b_early_strobe: got %0d want 0", oerr_val); else n_pass++;
        idle(1);
        n_checks++; if (oerr_val !== 1'b1 || oerr !== 24'd27 || ocnt !== 16'd3) $display("FAIL b2b_frame: got val=%0d err=%0d cnt=%0d want 1/27/3", oerr_val, oerr, ocnt); else n_pass++;
        idle(2);
    endtask

    task automatic test_restart();
        s0 = strobe_cnt;
        send(1'b1, 1'b0, 4'd2, 5, -3);
        send(1'b0, 1'b0, 4'd4, 8, -12);
        send(1'b1, 1'b0, 4'd4, 12, -12);
        send(1'b0, 1'b1, 4'd2, 5, -3);
        idle(6);
        n_checks++; if (strobe_cnt !== s0 + 1) $display("FAIL restart_strobes: got %0d want 1", strobe_cnt - s0); else n_pass++;
        n_checks++; if (oerr !== 24'd2 || ocnt !== 16'd2) $display("FAIL restart_frame: got err=%0d cnt=%0d want 2/2", oerr, ocnt); else n_pass++;
        s0 = strobe_cnt;
        send(1'b0, 1'b1, 4'd2, 5, -3);
        idle(6);
        n_checks++; if (strobe_cnt !== s0) $display("FAIL stray_eop: got %0d strobes want 0", strobe_cnt - s0); else n_pass++;
        n_checks++; if (oerr !== 24'd2 || ocnt !== 16'd2) $display("FAIL stray_eop_hold: got err=%0d cnt=%0d want 2/2", oerr, ocnt); else n_pass++;
    endtask

    task automatic send_g(input logic s, input logic e, input logic [3:0] q, input int re,
                          input int im);
        iclkena = 1'b1;
        drive(1'b1, s, e, q, re, im);
        tick();
        iclkena = 1'b0;
        tick();
        drive(1'b0, 1'b0, 1'b0, 4'd2, 0, 0);
    endtask

    task automatic idle_g();
        iclkena = 1'b1;
        tick();
        iclkena = 1'b0;
        tick();
    endtask

    task automatic test_clkena();
        s0 = strobe_cnt;
        send_g(1'b1, 1'b0, 4'd2, 5, -3);
        send_g(1'b0, 1'b0, 4'd4, 12, -12);
        n_checks++; if (oval !== 1'b0) $display("FAIL ce_early_oval: got %0d want 0", oval); else n_pass++;
        send_g(1'b0, 1'b1, 4'd10, 127, -128);
        n_checks++; if (oval !== 1'b1 || odat_re !== 5'd1) $display("FAIL ce_sym0: got val=%0d re=%0d want 1/1", oval, odat_re); else n_pass++;
        idle_g();
        n_checks++; if (oval !== 1'b1 || odat_re !== 5'd2) $display("FAIL ce_sym1: got val=%0d re=%0d want 1/2", oval, odat_re); else n_pass++;
        idle_g();
        n_checks++; if (oval !== 1'b1 || odat_re !== 5'd16) $display("FAIL ce_sym2: got val=%0d re=%0d want 1/16", oval, odat_re); else n_pass++;
        idle_g();
        n_checks++; if (oerr_val !== 1'b1 || oerr !== 24'd27 || ocnt !== 16'd3) $display("FAIL ce_frame: got val=%0d err=%0d cnt=%0d want 1/27/3", oerr_val, oerr, ocnt); else n_pass++;
        idle_g();
        n_checks++; if (oerr_val !== 1'b0 || oval !== 1'b0) $display("FAIL ce_after: got strobe=%0d val=%0d want 0/0", oerr_val, oval); else n_pass++;
        n_checks++; if (strobe_cnt !== s0 + 1) $display("FAIL ce_strobes: got %0d want 1", strobe_cnt - s0); else n_pass++;
        // Symbols presented while disabled must never be accepted
        s0 = strobe_cnt;
        iclkena = 1'b0;
        drive(1'b1, 1'b1, 1'b1, 4'd2, 5, -3);
        for (int i = 0; i < 4; i++) tick();
        drive(1'b0, 1'b0, 1'b0, 4'd2, 0, 0);
        iclkena = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++; if (oval !== 1'b0) $display("FAIL ce_off_oval[%0d]: got %0d want 0", i, oval); else n_pass++;
        end
        n_checks++; if (strobe_cnt !== s0 || oerr !== 24'd27) $display("FAIL ce_off_frame: got strobes=%0d err=%0d want 0/27", strobe_cnt - s0, oerr); else n_pass++;
    endtask

    task automatic test_reset_mid();
        s0 = strobe_cnt;
        send(1'b1, 1'b0, 4'd2, 5, -3);
        send(1'b0, 1'b0, 4'd2, 5, -3);
        send(1'b0, 1'b1, 4'd2, 5, -3);
        ireset = 1'b1;
        #1;
        n_checks++; if (oval !== 1'b0 || odat_re !== 5'd0 || odat_im !== 5'd0) $display("FAIL midrst_dat: got val=%0d re=%0d im=%0d want 0/0/0", oval, odat_re, odat_im); else n_pass++;
        n_checks++; if (oerr !== 24'd0 || ocnt !== 16'd0 || oerr_val !== 1'b0) $display("FAIL midrst_err: got err=%0d cnt=%0d val=%0d want 0/0/0", oerr, ocnt, oerr_val); else n_pass++;
        tick(); tick();
        ireset = 1'b0;
        s0 = strobe_cnt;
        for (int i = 0; i < 6; i++) begin
            tick();
            n_checks++; if (oval !== 1'b0) $display("FAIL midrst_inflight[%0d]: got %0d want 0", i, oval); else n_pass++;
        end
        n_checks++; if (strobe_cnt !== s0) $display("FAIL midrst_strobe: got %0d want 0", strobe_cnt - s0); else n_pass++;
        send(1'b0, 1'b1, 4'd2, 5, -3);
        idle(6);
        n_checks++; if (strobe_cnt !== s0) $display("FAIL midrst_idle_state: got %0d strobes want 0", strobe_cnt - s0); else n_pass++;
        send(1'b1, 1'b1, 4'd4, 8, -12);
        idle(3);
        n_checks++; if (oerr_val !== 1'b1 || oerr !== 24'd16 || ocnt !== 16'd1) $display("FAIL midrst_new: got val=%0d err=%0d cnt=%0d want 1/16/1", oerr_val, oerr, ocnt); else n_pass++;
        idle(2);
    endtask

    initial begin
        ireset = 1'b1; iclkena = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 4'd2, 0, 0);
        test_reset();
        test_qpsk();
        test_slicer();
        test_back_to_back();
        test_restart();
        test_clkena();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
